// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the HI/LO divide controller: FSM encoding and
// the fixed timeout and divide-by-zero constants.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } div_state_t;

  localparam logic [5:0]  DIV_TIMEOUT = 6'd63;
  localparam logic [31:0] DZ_LO       = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_ctrl.sv
// EX-stage controller for an external iterative divider: accepts DIV/DIVU,
// stalls the pipeline while the core runs and writes HI/LO once per divide.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_req,
  input  logic        ex_is_unsign,
  input  logic [31:0] ex_op_a,
  input  logic [31:0] ex_op_b,
  input  logic        flush,
  input  logic        stall_all,
  output logic        ex_stall,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        dz_flag,
  output logic        timeout,
  output logic        core_en,
  output logic        core_ready,
  output logic        core_flush,
  output logic        core_unsign,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic        core_busy,
  input  logic [63:0] core_out
);

  div_state_t  state_reg, state_next;
  logic        seen_busy_reg, seen_busy_next;
  logic [5:0]  wdog_reg, wdog_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic        unsign_reg, unsign_next;

  logic is_idle, is_run, is_done, is_abort;
  logic accept, div_zero, capture;

  assign is_idle  = (state_reg == ST_IDLE);
  assign is_run   = (state_reg == ST_RUN);
  assign is_done  = (state_reg == ST_DONE);
  assign is_abort = (state_reg == ST_ABORT);

  // rst gates acceptance so the combinational outputs are also 0 in reset
  assign accept   = rst & is_idle & ex_div_req & ~flush;
  assign div_zero = (ex_op_b == 32'd0);
  assign capture  = is_run & seen_busy_reg & ~core_busy;

  always_comb begin
    state_next     = state_reg;
    seen_busy_next = seen_busy_reg;
    wdog_next      = wdog_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    unsign_next    = unsign_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (div_zero) begin
            hi_next    = ex_op_a;
            lo_next    = DZ_LO;
            state_next = ST_DONE;
          end else begin
            a_next         = ex_op_a;
            b_next         = ex_op_b;
            unsign_next    = ex_is_unsign;
            seen_busy_next = 1'b0;
            wdog_next      = 6'd0;
            state_next     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        wdog_next = wdog_reg + 6'd1;
        if (core_busy) seen_busy_next = 1'b1;
        if (capture) begin
          hi_next    = core_out[63:32];
          lo_next    = core_out[31:0];
          state_next = ST_DONE;
        end else if (wdog_next == DIV_TIMEOUT) begin
          state_next = ST_ABORT;
        end
      end
      ST_DONE:  if (!stall_all) state_next = ST_IDLE;
      ST_ABORT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      seen_busy_reg <= 1'b0;
      wdog_reg      <= 6'd0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
      a_reg         <= 32'd0;
      b_reg         <= 32'd0;
      unsign_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      seen_busy_reg <= seen_busy_next;
      wdog_reg      <= wdog_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      unsign_reg    <= unsign_next;
    end
  end

  assign ex_stall    = accept | is_run;
  assign dz_flag     = accept & div_zero;
  assign hilo_we     = is_done & ~stall_all & ~flush;
  assign timeout     = is_abort & ~flush;
  // once the core has been seen busy, dropping core_en stops it restarting
  assign core_en     = is_run & ~(seen_busy_reg & ~core_busy);
  assign core_ready  = is_done;
  assign core_flush  = rst & (flush | is_abort);
  assign core_unsign = unsign_reg;
  assign core_a      = a_reg;
  assign core_b      = b_reg;
  assign hi_wdata    = hi_reg;
  assign lo_wdata    = lo_reg;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl with a behavioural iterative divider core and a HI/LO
// scoreboard; per-divide timing is recorded and compared after each run.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_div_req, ex_is_unsign, flush, stall_all;
  logic [31:0] ex_op_a, ex_op_b;
  logic        ex_stall, hilo_we, dz_flag, timeout;
  logic [31:0] hi_wdata, lo_wdata, core_a, core_b;
  logic        core_en, core_ready, core_flush, core_unsign, core_busy;
  logic [63:0] core_out;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];

  // core model controls
  logic core_dead;
  int   core_len;
  int   core_cnt;

  // per-divide observations
  int we_cycle, we_count, dz_cycle, to_cycle, stall_first, stall_last, stall_cnt;
  int ready_cnt, held;
  bit en_seen, en_after_we, unsign_bad, cflush_seen, to_flush;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk(clk), .rst(rst), .ex_div_req(ex_div_req), .ex_is_unsign(ex_is_unsign),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .flush(flush), .stall_all(stall_all),
    .ex_stall(ex_stall), .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .dz_flag(dz_flag), .timeout(timeout), .core_en(core_en), .core_ready(core_ready),
    .core_flush(core_flush), .core_unsign(core_unsign), .core_a(core_a), .core_b(core_b),
    .core_busy(core_busy), .core_out(core_out)
  );

  function automatic logic [63:0] exp_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic uns);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (uns) begin
      q = a / b;
      r = a % b;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // busy for core_len cycles starting the cycle after core_en
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_busy <= 1'b0;
      core_cnt  <= 0;
      core_out  <= 64'd0;
    end else if (core_flush) begin
      core_busy <= 1'b0;
      core_cnt  <= 0;
    end else if (core_busy) begin
      if (core_cnt == 1) core_busy <= 1'b0;
      core_cnt <= core_cnt - 1;
    end else if (core_en && !core_dead) begin
      core_busy <= 1'b1;
      core_cnt  <= core_len;
      core_out  <= exp_div(core_a, core_b, core_unsign);
    end
  end

  always @(negedge clk) begin
    if (rst && hilo_we) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_spurious_write", 1, 0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        $display("hilo write hi=%h lo=%h (exp hi=%h lo=%h)", hi_wdata, lo_wdata, e[63:32], e[31:0]);
        check_eq("sb_hi", hi_wdata, e[63:32]);
        check_eq("sb_lo", lo_wdata, e[31:0]);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1. Cycle 0 is the request cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic uns,
                        input int flush_at, input int hold, input bit expect_write);
    int cyc, post, post_n;
    bit done, req_was;
    we_cycle = -1; we_count = 0; dz_cycle = -1; to_cycle = -1;
    stall_first = -1; stall_last = -1; stall_cnt = 0; ready_cnt = 0; held = 0;
    en_seen = 0; en_after_we = 0; unsign_bad = 0; cflush_seen = 0; to_flush = 0;
    ex_op_a = a; ex_op_b = b; ex_is_unsign = uns; ex_div_req = 1'b1;
    stall_all = (hold > 0);
    if (expect_write) exp_q.push_back(exp_div(a, b, uns));
    post_n = (flush_at >= 0) ? 1 : 2;
    cyc = 0; post = 0; done = 0;
    while (!done) begin
      req_was = ex_div_req;
      if (cyc == flush_at) flush = 1'b1;
      @(negedge clk);
      if (ex_stall) begin
        stall_cnt++;
        if (stall_first < 0) stall_first = cyc;
        stall_last = cyc;
      end
      if (core_en) en_seen = 1;
      if (core_en && we_cycle >= 0) en_after_we = 1;
      if (cyc >= 1 && we_cycle < 0 && core_unsign !== uns) unsign_bad = 1;
      if (dz_flag) dz_cycle = cyc;
      if (timeout) begin
        to_cycle = cyc;
        to_flush = core_flush;
      end
      if (cyc == flush_at && core_flush) cflush_seen = 1;
      if (core_ready) ready_cnt++;
      if (core_ready && stall_all) held++;
      if (hilo_we) begin
        we_count++;
        if (we_cycle < 0) we_cycle = cyc;
      end
      @(posedge clk); #1;
      flush = 1'b0;
      if (stall_all && held >= hold) stall_all = 1'b0;
      if (we_cycle >= 0 || to_cycle >= 0 || (flush_at >= 0 && cyc >= flush_at))
        ex_div_req = 1'b0;
      if (!req_was) post++;
      if (post >= post_n) done = 1;
      cyc++;
      if (cyc > 300) begin
        check_eq("cycle_bound", cyc, 0);
        ex_div_req = 1'b0;
        stall_all  = 1'b0;
        done = 1;
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        ru;
    int          n_we, n_en;
    rst = 1'b0; ex_div_req = 1'b1; ex_is_unsign = 1'b0; flush = 1'b1; stall_all = 1'b0;
    ex_op_a = 32'd5; ex_op_b = 32'd0; core_dead = 1'b0; core_len = 32;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs_zero", |{ex_stall, hilo_we, hi_wdata, lo_wdata, dz_flag, timeout,
             core_en, core_ready, core_flush, core_unsign, core_a, core_b}, 0);
    ex_div_req = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    $display("txn DIVU 100/7");
    do_div(32'd100, 32'd7, 1'b1, -1, 0, 1);
    check_eq("divu_stall_first", stall_first, 0);
    check_eq("divu_stall_last", stall_last, 34);
    check_eq("divu_stall_cnt", stall_cnt, 35);
    check_eq("divu_we_cycle", we_cycle, 35);
    check_eq("divu_we_count", we_count, 1);

    $display("txn DIV -7/2");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, -1, 0, 1);
    check_eq("div_unsign_held", unsign_bad, 0);
    check_eq("div_we_cycle", we_cycle, 35);

    $display("txn DIV 5/0");
    do_div(32'd5, 32'd0, 1'b0, -1, 0, 1);
    check_eq("dz_flag_cycle", dz_cycle, 0);
    check_eq("dz_we_cycle", we_cycle, 1);
    check_eq("dz_core_en", en_seen, 0);
    check_eq("dz_stall_last", stall_last, 0);

    $display("txn flush at cycle 10");
    do_div(32'd100, 32'd7, 1'b1, 10, 0, 0);
    check_eq("flush_core_flush", cflush_seen, 1);
    check_eq("flush_no_we", we_count, 0);
    check_eq("flush_stall_last", stall_last, 10);
    check_eq("flush_no_dz", dz_cycle, -1);
    check_eq("flush_no_timeout", to_cycle, -1);
    $display("txn DIVU 1000/9 after flush");
    do_div(32'd1000, 32'd9, 1'b1, -1, 0, 1);
    check_eq("postflush_we_cycle", we_cycle, 35);

    $display("txn DIVU 77/5 with stall_all hold");
    do_div(32'd77, 32'd5, 1'b1, -1, 3, 1);
    check_eq("hold_ready_cnt", ready_cnt, 4);
    check_eq("hold_we_count", we_count, 1);
    check_eq("hold_we_cycle", we_cycle, 38);
    check_eq("hold_no_restart", en_after_we, 0);

    for (int i = 0; i < 5; i++) begin
      core_len = $urandom_range(4, 40);
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      ru = 1'($urandom_range(0, 1));
      $display("txn random a=%h b=%h uns=%0d len=%0d", ra, rb, ru, core_len);
      do_div(ra, rb, ru, -1, 0, 1);
      check_eq("rand_we_cycle", we_cycle, (rb == 32'd0) ? 1 : core_len + 3);
    end
    core_len = 32;

    $display("txn timeout, dead core");
    core_dead = 1'b1;
    do_div(32'd9, 32'd4, 1'b1, -1, 0, 0);
    check_eq("to_cycle", to_cycle, 64);
    check_eq("to_core_flush", to_flush, 1);
    check_eq("to_no_we", we_count, 0);
    check_eq("to_stall_last", stall_last, 63);
    core_dead = 1'b0;

    $display("txn reset mid-run");
    ex_op_a = 32'd1000; ex_op_b = 32'd3; ex_is_unsign = 1'b1; ex_div_req = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_outputs_zero", |{ex_stall, hilo_we, hi_wdata, lo_wdata, dz_flag, timeout,
             core_en, core_ready, core_flush, core_unsign, core_a, core_b}, 0);
    @(posedge clk); #1;
    ex_div_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_we = 0; n_en = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hilo_we) n_we++;
      if (core_en) n_en++;
    end
    check_eq("rst_no_we", n_we, 0);
    check_eq("rst_no_core_en", n_en, 0);
    @(posedge clk); #1;
    $display("txn DIVU 50/6 after reset");
    do_div(32'd50, 32'd6, 1'b1, -1, 0, 1);
    check_eq("postrst_we_cycle", we_cycle, 35);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port ex_div_req, input, 1 bit: the EX-stage instruction is DIV/DIVU.
REQ-004 The block SHALL have the port ex_is_unsign, input, 1 bit: 1 = DIVU, 0 = DIV.
REQ-005 The block SHALL have the ports ex_op_a and ex_op_b, input, 32 bits each: dividend and divisor.
REQ-006 The block SHALL have the port flush, input, 1 bit: pipeline flush; kills any in-flight divide.
REQ-007 The block SHALL have the port stall_all, input, 1 bit: the pipeline is frozen by another source.
REQ-008 The block SHALL have the port ex_stall, output, 1 bit: stall request to the hazard unit.
REQ-009 The block SHALL have the ports hilo_we, output, 1 bit, and hi_wdata and lo_wdata, output, 32 bits each: HI/LO write port, HI = remainder, LO = quotient.
REQ-010 The block SHALL have the ports dz_flag and timeout, output, 1 bit each: one-cycle pulses.
REQ-011 The block SHALL have the core-side outputs core_en, core_ready, core_flush, core_unsign (1 bit each) and core_a, core_b (32 bits each).
REQ-012 The block SHALL have the core-side inputs core_busy (1 bit) and core_out (64 bits, {rem, quo}).

Function
REQ-013 The state machine SHALL have exactly four states, IDLE, RUN, DONE and ABORT; ABORT is a one-cycle state that returns to IDLE.
REQ-014 In IDLE with ex_div_req=1, flush=0 and ex_op_b!=0, the block SHALL latch ex_op_a, ex_op_b and ex_is_unsign, clear seen_busy and the watchdog counter, and go to RUN.
REQ-015 In IDLE with ex_div_req=1, flush=0 and ex_op_b==0, the block SHALL load the result registers with hi=ex_op_a and lo=32'hFFFF_FFFF, pulse dz_flag and go to DONE, without using the core.
REQ-016 The block SHALL drive ex_stall = (IDLE & ex_div_req & ~flush) | RUN, combinationally; ex_stall SHALL be 0 in DONE and ABORT.
REQ-017 The block SHALL drive core_en = RUN & ~(seen_busy & ~core_busy), so that the core never restarts after finishing.
REQ-018 In RUN, seen_busy SHALL be set when core_busy=1; when seen_busy=1 and core_busy=0, the block SHALL capture core_out into the result registers (hi = core_out[63:32], lo = core_out[31:0]) and go to DONE.
REQ-019 The block SHALL hold core_a, core_b and core_unsign at the latched values from the cycle of acceptance until it leaves DONE.
REQ-020 The block SHALL drive core_ready = DONE.
REQ-021 In DONE with stall_all=1, the block SHALL remain in DONE with hilo_we=0.
REQ-022 In DONE with stall_all=0, the block SHALL assert hilo_we for exactly one cycle and go to IDLE; an ex_div_req seen in the following cycle is a new instruction.
REQ-023 The block SHALL drive hi_wdata and lo_wdata from the result registers at all times; they are meaningful only while hilo_we=1.
REQ-024 Normal latency SHALL be: acceptance in cycle 0, RUN from cycle 1, and with a 32-cycle core_busy, capture in cycle 34 and hilo_we in cycle 35.
REQ-025 A watchdog SHALL be a 6-bit counter that increments every RUN cycle.
REQ-026 When the watchdog reaches DIV_TIMEOUT (63) without capture, the block SHALL go to ABORT, pulse timeout in ABORT, assert core_flush, and never assert hilo_we for that divide.
REQ-027 Flush SHALL have priority in every state: next state IDLE, hilo_we=0 in that cycle, core_flush=1 whenever flush=1 or in ABORT, and no acceptance in IDLE.
REQ-028 A divide that is killed by flush SHALL NOT pulse dz_flag or timeout.

Reset
REQ-029 When rst=0, the block SHALL asynchronously force IDLE, clear seen_busy, the watchdog counter, the result registers and the latched operands, and drive every output to 0.
REQ-030 If reset is asserted mid-divide, the block SHALL NOT perform a HI/LO write after reset is released; the core receives core_en=0.

Structure
REQ-031 The shared package div_ctrl_pkg SHALL hold the state enum, DIV_TIMEOUT=63 and DZ_LO=32'hFFFF_FFFF.
REQ-032 The block SHALL contain no sub-module; the iterative divider core is instantiated beside it and connected through the core_* ports.

Verification
REQ-033 The bench SHALL check: DIVU 100/7, 32-cycle core -> ex_stall high for cycles 0-34, hilo_we in cycle 35 with hi=2 and lo=14.
REQ-034 The bench SHALL check: DIV -7/2 -> hi=0xFFFFFFFF and lo=0xFFFFFFFD; core_unsign=0 held for the whole divide.
REQ-035 The bench SHALL check: DIV 5/0 -> dz_flag in cycle 0, hilo_we in cycle 1 with hi=5 and lo=0xFFFFFFFF, core_en never asserted.
REQ-036 The bench SHALL check: flush in cycle 10 of RUN -> IDLE next cycle, core_flush=1, no hilo_we; a new request in cycle 12 completes normally.
REQ-037 The bench SHALL check: stall_all high for 3 cycles at completion -> DONE held, hilo_we exactly once after release, no second divide started.
REQ-038 The bench SHALL check: core_busy forced to 0 -> timeout pulse after 63 RUN cycles, no write; and rst=0 mid-RUN -> all outputs 0 immediately.
